// File: rtl/skid_buffer_pkg.sv
// Shared types and default widths for the skid buffer register slice.
package skid_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_e;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int CNT_WIDTH_DEFAULT  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Only compiled when SKID_STATS_EN is defined, since nothing else uses it.
`ifdef SKID_STATS_EN
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice with registered in_ready and out_valid.
// Define SKID_STATS_EN to add stall/full statistics counters and their ports.
module skid_buffer
    import skid_buffer_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEFAULT,
    parameter int cnt_width  = CNT_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [data_width-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data,
    input  logic                  out_ready
`ifdef SKID_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [cnt_width-1:0]  stall_cnt,
    output logic [cnt_width-1:0]  full_cnt
`endif
);

    skid_state_e           state;
    skid_state_e           next_state;
    logic [data_width-1:0] main_reg;
    logic [data_width-1:0] skid_reg;
    logic                  in_fire;
    logic                  out_fire;
    logic                  load_main;
    logic                  main_from_skid;
    logic                  load_skid;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign out_data = main_reg;

    always_comb begin
        next_state     = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    next_state = BUSY;
                    load_main  = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    next_state = FULL;
                    load_skid  = 1'b1;
                end else if (out_fire) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the downstream side can move
                if (out_fire) begin
                    next_state     = BUSY;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Handshake outputs come from next_state so neither has a combinational input path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state     <= next_state;
            out_valid <= (next_state != EMPTY);
            in_ready  <= (next_state != FULL);
            if (load_main) begin
                main_reg <= main_from_skid ? skid_reg : in_data;
            end
            if (load_skid) begin
                skid_reg <= in_data;
            end
        end
    end

`ifdef SKID_STATS_EN
    sat_counter #(.width(cnt_width)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clr),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

    sat_counter #(.width(cnt_width)) u_full_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clr),
        .inc   (state == FULL),
        .count (full_cnt)
    );
`else
    logic [cnt_width-1:0] stats_unused;
    assign stats_unused = '0;
`endif

endmodule
